// File: rtl/bp_burst_mem_responder.sv
// bp_burst_mem_responder: single-outstanding burst memory responder over a dword array,
// with byte-masked sub-dword writes and critical-word-first wrapping within a burst.
module bp_burst_mem_responder #(
  parameter int paddr_width_p   = 40,
  parameter int dword_width_p   = 64,
  parameter int payload_width_p = 16,
  parameter int mem_els_p       = 1024,
  localparam int hdr_w          = 7 + paddr_width_p + payload_width_p
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [hdr_w-1:0]         mem_cmd_header_i,
  input  logic                     mem_cmd_header_v_i,
  output logic                     mem_cmd_header_ready_o,
  input  logic [dword_width_p-1:0] mem_cmd_data_i,
  input  logic                     mem_cmd_data_v_i,
  output logic                     mem_cmd_data_ready_o,
  output logic [hdr_w-1:0]         mem_resp_header_o,
  output logic                     mem_resp_header_v_o,
  input  logic                     mem_resp_header_ready_i,
  output logic [dword_width_p-1:0] mem_resp_data_o,
  output logic                     mem_resp_data_v_o,
  input  logic                     mem_resp_data_ready_i
);
  localparam int lg = $clog2(mem_els_p);
  typedef enum logic [1:0] {e_ready, e_cmd_data, e_resp_header, e_resp_data} state_e;
  state_e state_r, state_n;
  logic [hdr_w-1:0] hdr_r, hdr_n;
  logic [3:0] cnt_r, cnt_n, nm1;
  logic [4:0] beats;
  logic [2:0] size, a_lo, off;
  logic [3:0] msg_type;
  logic is_rd, in_wr, last, wr_en;
  logic hdr_rdy, dat_rdy, rsp_hv, rsp_dv;
  logic [lg-1:0] base, mask, idx;
  logic [7:0] lanes, be;
  logic [dword_width_p-1:0] bm;
  logic [dword_width_p-1:0] mem [mem_els_p];
  assign msg_type = hdr_r[3:0];
  assign size     = hdr_r[6:4];
  assign a_lo     = hdr_r[9:7];
  assign base     = hdr_r[10 +: lg];
  assign is_rd    = (msg_type == 4'd0) || (msg_type == 4'd2);
  assign in_wr    = (mem_cmd_header_i[3:0] == 4'd1) || (mem_cmd_header_i[3:0] == 4'd3);
  assign beats    = size < 3'd3 ? 5'd1 : 5'd1 << (size - 3'd3);
  assign nm1      = 4'(beats - 5'd1);
  assign last     = cnt_r == nm1;
  // burst wraps inside the aligned N-dword block, starting at the requested dword
  assign mask     = lg'(nm1);
  assign idx      = (base & ~mask) | ((base + lg'(cnt_r)) & mask);
  assign lanes    = size == 3'd0 ? 8'h01 : size == 3'd1 ? 8'h03 : size == 3'd2 ? 8'h0F : 8'hFF;
  assign off      = size == 3'd0 ? a_lo : size == 3'd1 ? {a_lo[2:1], 1'b0} : size == 3'd2 ? {a_lo[2], 2'b00} : 3'd0;
  assign be       = lanes << off;
  always_comb begin
    bm = '0;
    for (int i = 0; i < 8; i++) bm[i*8 +: 8] = {8{be[i]}};
  end
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    hdr_n   = hdr_r;
    hdr_rdy = 1'b0;
    dat_rdy = 1'b0;
    rsp_hv  = 1'b0;
    rsp_dv  = 1'b0;
    unique case (state_r)
      e_ready: begin
        hdr_rdy = 1'b1;
        if (mem_cmd_header_v_i) begin
          hdr_n   = mem_cmd_header_i;
          cnt_n   = '0;
          state_n = in_wr ? e_cmd_data : e_resp_header;
        end
      end
      e_cmd_data: begin
        dat_rdy = 1'b1;
        if (mem_cmd_data_v_i) begin
          cnt_n   = last ? 4'd0 : cnt_r + 4'd1;
          state_n = last ? e_resp_header : e_cmd_data;
        end
      end
      e_resp_header: begin
        rsp_hv = 1'b1;
        if (mem_resp_header_ready_i) begin
          cnt_n   = '0;
          state_n = is_rd ? e_resp_data : e_ready;
        end
      end
      e_resp_data: begin
        rsp_dv = 1'b1;
        if (mem_resp_data_ready_i) begin
          cnt_n   = last ? 4'd0 : cnt_r + 4'd1;
          state_n = last ? e_ready : e_resp_data;
        end
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_ready;
      cnt_r   <= '0;
      hdr_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      hdr_r   <= hdr_n;
    end
  end
  // handshakes are gated by reset so the outputs drop the moment reset asserts
  assign mem_cmd_header_ready_o = reset_n_i & hdr_rdy;
  assign mem_cmd_data_ready_o   = reset_n_i & dat_rdy;
  assign mem_resp_header_v_o    = reset_n_i & rsp_hv;
  assign mem_resp_data_v_o      = reset_n_i & rsp_dv;
  assign mem_resp_header_o      = hdr_r;
  assign mem_resp_data_o        = mem_resp_data_v_o ? mem[idx] : '0;
  assign wr_en                  = mem_cmd_data_ready_o & mem_cmd_data_v_i;
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[idx] <= (mem[idx] & ~bm) | (mem_cmd_data_i & bm);
  end
endmodule

// File: tb/tb_bp_burst_mem_responder.sv
// tb_bp_burst_mem_responder: table of transactions plus corner sequences, responses
// checked against a reference memory model through header/data scoreboards.
module tb_bp_burst_mem_responder;
  localparam int AW = 40;
  localparam int HW = 63;
  localparam int ME = 1024;
  typedef struct {
    logic [3:0]  t;
    logic [2:0]  sz;
    logic [39:0] addr;
    logic [63:0] d0;
    logic        ce;
    logic [63:0] e0;
    int          lat;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [HW-1:0] cmd_hdr = '0;
  logic hdr_v = 1'b0, hdr_ready;
  logic [63:0] cmd_dat = '0;
  logic dat_v = 1'b0, dat_ready;
  logic [HW-1:0] rsp_hdr;
  logic rsp_hv, hready = 1'b1;
  logic [63:0] rsp_dat;
  logic rsp_dv, dready = 1'b1;
  int n_cmp = 0, n_fail = 0, cyc = 0, hv_cyc = 0, acc_cyc = 0;
  logic hv_prev = 1'b0;
  logic [63:0] mem_m [ME];
  logic [HW-1:0] exp_hdr_q [$];
  logic [63:0] exp_dat_q [$];
  vec_t vecs [16];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bp_burst_mem_responder dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .mem_cmd_header_i(cmd_hdr), .mem_cmd_header_v_i(hdr_v), .mem_cmd_header_ready_o(hdr_ready),
    .mem_cmd_data_i(cmd_dat), .mem_cmd_data_v_i(dat_v), .mem_cmd_data_ready_o(dat_ready),
    .mem_resp_header_o(rsp_hdr), .mem_resp_header_v_o(rsp_hv), .mem_resp_header_ready_i(hready),
    .mem_resp_data_o(rsp_dat), .mem_resp_data_v_o(rsp_dv), .mem_resp_data_ready_i(dready)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic int nbeats(input logic [2:0] sz);
    return sz < 3 ? 1 : 1 << (sz - 3);
  endfunction
  function automatic int idx_of(input logic [39:0] a, input logic [2:0] sz, input int k);
    int n, b;
    n = nbeats(sz);
    b = int'((a >> 3) % ME);
    return b - b % n + (b + k) % n;
  endfunction
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [39:0] a, input logic [2:0] sz);
    logic [63:0] r;
    int nb, off;
    if (sz >= 3) return d;
    nb = 1 << sz;
    off = int'(a[2:0]) / nb * nb;
    r = old;
    for (int b = off; b < off + nb; b++) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction
  always @(negedge clk) begin
    if (reset_n) begin
      if (rsp_hv && !hv_prev) hv_cyc = cyc;
      hv_prev = rsp_hv;
      if (rsp_hv && hready) begin
        if (exp_hdr_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL resp_hdr_unexpected: got %h expected none", rsp_hdr);
        end else check("resp_hdr", 64'(rsp_hdr), 64'(exp_hdr_q.pop_front()));
      end
      if (rsp_dv && dready) begin
        if (exp_dat_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL resp_dat_unexpected: got %h expected none", rsp_dat);
        end else check("resp_dat", rsp_dat, exp_dat_q.pop_front());
      end
    end else hv_prev = 1'b0;
  end
  task automatic send_hdr(input logic [HW-1:0] h);
    int t;
    t = 0;
    @(posedge clk); #1;
    hdr_v = 1'b1; cmd_hdr = h;
    do begin @(negedge clk); t++; end while (!hdr_ready && t < 50);
    if (!hdr_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL hdr_accept_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    hdr_v = 1'b0; cmd_hdr = HW'({$urandom(), $urandom()});
  endtask
  task automatic send_beat(input logic [63:0] d, input logic [39:0] a, input logic [2:0] sz, input int k);
    int t, i;
    t = 0;
    dat_v = 1'b1; cmd_dat = d;
    do begin @(negedge clk); t++; end while (!dat_ready && t < 50);
    if (!dat_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL beat_accept_timeout: got ready=0 expected ready=1");
    end
    i = idx_of(a, sz, k);
    mem_m[i] = merge(mem_m[i], d, a, sz);
    @(posedge clk); #1;
    dat_v = 1'b0; cmd_dat = {$urandom(), $urandom()};
  endtask
  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_hdr_q.size() != 0 || exp_dat_q.size() != 0) && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", exp_hdr_q.size(), exp_dat_q.size());
      exp_hdr_q.delete(); exp_dat_q.delete();
    end
  endtask
  task automatic run(input vec_t v);
    logic [HW-1:0] h;
    int n;
    h = {16'($urandom()), v.addr, v.sz, v.t};
    n = nbeats(v.sz);
    exp_hdr_q.push_back(h);
    if (v.t == 4'd0 || v.t == 4'd2)
      for (int k = 0; k < n; k++) exp_dat_q.push_back((k == 0 && v.ce) ? v.e0 : mem_m[idx_of(v.addr, v.sz, k)]);
    send_hdr(h);
    if (v.t == 4'd1 || v.t == 4'd3)
      for (int k = 0; k < n; k++) send_beat(v.d0 + 64'(k), v.addr, v.sz, k);
    wait_drain();
    if (v.lat != 0) check("latency", 64'(hv_cyc - acc_cyc + 1), 64'(v.lat));
  endtask
  initial begin
    vec_t v;
    logic [HW-1:0] h;
    int t;
    vecs[0]  = '{4'd1, 3'd6, 40'h40,   64'h1000, 1'b0, 64'h0, 0};
    vecs[1]  = '{4'd0, 3'd6, 40'h40,   64'h0, 1'b1, 64'h1000, 1};
    vecs[2]  = '{4'd0, 3'd6, 40'h58,   64'h0, 1'b1, 64'h1003, 1};
    vecs[3]  = '{4'd3, 3'd0, 40'h41,   64'hAB00, 1'b0, 64'h0, 2};
    vecs[4]  = '{4'd0, 3'd3, 40'h40,   64'h0, 1'b1, 64'hAB00, 1};
    vecs[5]  = '{4'd1, 3'd3, 40'h1000, 64'hDEAD0000, 1'b0, 64'h0, 2};
    vecs[6]  = '{4'd2, 3'd3, 40'h1000, 64'h0, 1'b1, 64'hDEAD0000, 1};
    vecs[7]  = '{4'd1, 3'd4, 40'h208,  64'h5550, 1'b0, 64'h0, 0};
    vecs[8]  = '{4'd0, 3'd4, 40'h200,  64'h0, 1'b1, 64'h5551, 1};
    vecs[9]  = '{4'd1, 3'd3, 40'h0,    64'h0123456789ABCDEF, 1'b0, 64'h0, 2};
    vecs[10] = '{4'd3, 3'd1, 40'h2003, 64'h123456789ABCDEF0, 1'b0, 64'h0, 2};
    vecs[11] = '{4'd0, 3'd3, 40'h0,    64'h0, 1'b1, 64'h012345679ABCCDEF, 1};
    vecs[12] = '{4'd3, 3'd2, 40'h6,    64'hAABBCCDD11223344, 1'b0, 64'h0, 2};
    vecs[13] = '{4'd0, 3'd3, 40'h2000, 64'h0, 1'b1, 64'hAABBCCDD9ABCCDEF, 1};
    vecs[14] = '{4'd7, 3'd3, 40'h40,   64'h0, 1'b0, 64'h0, 1};
    vecs[15] = '{4'd0, 3'd6, 40'h40,   64'h0, 1'b1, 64'hAB00, 1};
    #3;
    check("rst_hdr_ready", 64'(hdr_ready), 64'd0);
    check("rst_dat_ready", 64'(dat_ready), 64'd0);
    check("rst_rsp_hv", 64'(rsp_hv), 64'd0);
    check("rst_rsp_dv", 64'(rsp_dv), 64'd0);
    check("rst_rsp_hdr", 64'(rsp_hdr), 64'd0);
    check("rst_rsp_dat", rsp_dat, 64'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_hdr_ready", 64'(hdr_ready), 64'd1);
    for (int i = 0; i < 16; i++) run(vecs[i]);
    // read stalled on response data: first beat must be held without advancing
    dready = 1'b0;
    h = {16'h5A5A, 40'h40, 3'd6, 4'd0};
    exp_hdr_q.push_back(h);
    for (int k = 0; k < 8; k++) exp_dat_q.push_back(mem_m[idx_of(40'h40, 3'd6, k)]);
    send_hdr(h);
    t = 0;
    while (!rsp_dv && t < 20) begin @(negedge clk); t++; end
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", 64'(rsp_dv), 64'd1);
      check("stall_data", rsp_dat, mem_m[8]);
      check("stall_hdr_ready", 64'(hdr_ready), 64'd0);
      @(negedge clk);
    end
    dready = 1'b1;
    wait_drain();
    // reset in the middle of an 8-beat write
    v = '{4'd1, 3'd6, 40'h80, 64'h2000, 1'b0, 64'h0, 0};
    run(v);
    send_hdr({16'h0, 40'h80, 3'd6, 4'd1});
    for (int k = 0; k < 3; k++) send_beat(64'h3000 + 64'(k), 40'h80, 3'd6, k);
    dat_v = 1'b1; cmd_dat = 64'h3003;
    #2 reset_n = 1'b0;
    #1;
    check("abort_hdr_ready", 64'(hdr_ready), 64'd0);
    check("abort_dat_ready", 64'(dat_ready), 64'd0);
    check("abort_rsp_hv", 64'(rsp_hv), 64'd0);
    check("abort_rsp_dv", 64'(rsp_dv), 64'd0);
    check("abort_rsp_hdr", 64'(rsp_hdr), 64'd0);
    check("abort_rsp_dat", rsp_dat, 64'd0);
    @(posedge clk); #1;
    dat_v = 1'b0;
    check("abort_hold_hdr_ready", 64'(hdr_ready), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_release_hdr_ready", 64'(hdr_ready), 64'd1);
    v = '{4'd0, 3'd6, 40'h80, 64'h0, 1'b1, 64'h3000, 1};
    run(v);
    check("abort_model_beat3", mem_m[19], 64'h2003);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/bp_burst_mem_responder.md
BP_BURST_MEM_RESPONDER -- requirements
Module: bp_burst_mem_responder

Interface
REQ-001 Parameter paddr_width_p, default 40, physical address width.
REQ-002 Parameter dword_width_p, default 64, data beat width (fixed at 64).
REQ-003 Parameter payload_width_p, default 16, opaque payload echoed to the response.
REQ-004 Parameter mem_els_p, default 1024, backing-store depth in dwords; power of 2.
REQ-005 Header layout, LSB first: msg_type[3:0], size[2:0], addr[paddr_width_p-1:0], payload; width hdr_w = 7+paddr_width_p+payload_width_p.
REQ-006 msg_type encodings: 0 rd, 1 wr, 2 uc_rd, 3 uc_wr, others unsupported.
REQ-007 size encodes bytes = 2^size, range 1..64; beats N = max(1, bytes/8).
REQ-008 One clock; reset is asynchronous and active-low.
REQ-009 clk_i  in  1  clock, all state on rising edge.
REQ-010 reset_n_i  in  1  asynchronous active-low reset.
REQ-011 mem_cmd_header_i / _v_i / _ready_o  in/in/out  hdr_w/1/1  command header, ready&valid.
REQ-012 mem_cmd_data_i / _v_i / _ready_o  in/in/out  64/1/1  command data beats, ready&valid.
REQ-013 mem_resp_header_o / _v_o / _ready_i  out/out/in  hdr_w/1/1  response header, ready&valid.
REQ-014 mem_resp_data_o / _v_o / _ready_i  out/out/in  64/1/1  response data beats, ready&valid.

Function
REQ-015 FSM states: e_ready, e_cmd_data, e_resp_header, e_resp_data; one transaction in flight.
REQ-016 A transfer occurs on a cycle where valid and ready are both 1; valid never depends on ready.
REQ-017 e_ready: header_ready_o=1; on header transfer, latch header, clear beat counter.
REQ-018 From e_ready: wr/uc_wr -> e_cmd_data; rd/uc_rd/unsupported -> e_resp_header.
REQ-019 e_cmd_data: data_ready_o=1; each beat transfer writes memory, increments counter; after beat N-1 -> e_resp_header.
REQ-020 e_resp_header: resp_header_v_o=1, header equals latched command header bit-for-bit; on transfer: reads -> e_resp_data, else -> e_ready.
REQ-021 e_resp_data: resp_data_v_o=1, data = memory dword for current beat; after beat N-1 transfer -> e_ready.
REQ-022 Beat k dword index: base = (addr>>3) mod mem_els_p; index = (base & ~(N-1)) | ((base+k) & (N-1)) -- wraps within aligned N-dword block (critical word first).
REQ-023 Writes with size<3 update only bytes [addr[2:0] & ~(bytes-1)] through +bytes-1 of the dword, taking them from the same byte lanes of the beat; size>=3 writes full dwords.
REQ-024 Reads always return full dwords regardless of size.
REQ-025 Unsupported msg_type: no memory access, header-only response.
REQ-026 Addresses beyond mem_els_p*8 bytes alias modulo array size.
REQ-027 Memory read is combinational from the array; write visible to a read on the next cycle.
REQ-028 Command header and data inputs are ignored outside their ready states.
REQ-029 Minimum latency: write N=1 resp header valid 2 cycles after header accepted; read resp header valid 1 cycle after.

Reset
REQ-030 While reset_n_i=0: state e_ready, counter 0, all ready/valid outputs 0, header/data outputs 0.
REQ-031 First cycle after deassertion: mem_cmd_header_ready_o=1.
REQ-032 Reset assertion mid-transaction aborts it immediately; partial writes already done remain; memory contents never reset.

Verification
REQ-033 wr size=6 addr 0x40, beats 0..7 = 0x1000+k, resp ready=1 -> one resp header equal to cmd; then rd same -> 8 beats 0x1000..0x1007.
REQ-034 rd size=6 addr 0x58 after REQ-033 -> beats 0x1003,0x1004..0x1007,0x1000,0x1001,0x1002 (wrap).
REQ-035 uc_wr size=0 addr 0x41 data 0xAB00 over dword 0x1000 -> rd size=3 addr 0x40 returns 0xAB00.
REQ-036 Read with resp_data_ready_i held 0 for 5 cycles -> valid held, data stable, no beat skipped; header_ready_o=0 throughout.
REQ-037 Assert reset_n_i after 3 of 8 write beats -> outputs 0 asynchronously; after release, header_ready_o=1; read shows 3 beats written, rest old.
REQ-038 msg_type 7 -> header-only response, memory unchanged.
